// File: rtl/symbol_serializer_pkg.sv
// rtl/symbol_serializer_pkg.sv - shared constants, state encoding and index-width helper
//
// Purpose: definitions common to symbol_serializer and its sub-module.
//   SYM_IDLE  : value driven on num while no symbol is valid.
//   state_e   : serializer FSM state encoding.
//   idx_width : width of a symbol index for n symbols per word (clog2, min 1).
package symbol_serializer_pkg;

  localparam logic [1:0] SYM_IDLE = 2'b00;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  function automatic int idx_width(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/symbol_serializer_pend_buf.sv
// rtl/symbol_serializer_pend_buf.sv - one-entry pending word buffer
//
// Purpose: holds the next word while the current word shifts out.
// Ports:
//   clk, reset   : clock, synchronous active-high reset (empties the buffer)
//   wr_i         : store wr_data_i and mark full
//   wr_data_i    : word to store
//   take_i       : consume the stored word (clears full)
//   full_o       : buffer holds a word
//   data_o       : stored word
module word_pend_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wr_i,
  input  logic [W-1:0] wr_data_i,
  input  logic         take_i,
  output logic         full_o,
  output logic [W-1:0] data_o
);

  logic         full_q;
  logic [W-1:0] data_q;

  // The serializer never writes and takes in the same cycle: it only writes
  // when the current word is not finishing, and only takes when it is.
  always_ff @(posedge clk) begin
    if (reset) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else if (wr_i) begin
      full_q <= 1'b1;
      data_q <= wr_data_i;
    end else if (take_i) begin
      full_q <= 1'b0;
    end
  end

  assign full_o = full_q;
  assign data_o = data_q;

endmodule

// File: rtl/symbol_serializer.sv
// rtl/symbol_serializer.sv - word to symbol-stream serializer with one-word pending buffer
//
// Purpose: accepts DATA_W-bit words (valid/ready) and emits DATA_W/SYM_W
// symbols per word on num (valid/ready/last), with no bubble between words.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   in_data/in_valid    : input word and its qualifier
//   in_ready            : a word can be accepted this cycle (registered state only)
//   num/num_valid       : current symbol (SYM_IDLE when not valid)
//   num_ready           : downstream takes num this cycle
//   num_last            : num is the final symbol of its word
//   busy                : a word is shifting out or waiting in the pending buffer
//   sym_count           : saturating count of transferred symbols
module symbol_serializer
  import symbol_serializer_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int SYM_W     = 2,
  parameter int MSB_FIRST = 1,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [SYM_W-1:0]  num,
  output logic              num_valid,
  input  logic              num_ready,
  output logic              num_last,
  output logic              busy,
  output logic [CNT_W-1:0]  sym_count
);

  localparam int N     = DATA_W / SYM_W;
  localparam int IDX_W = idx_width(N);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_e              state_q;
  logic [DATA_W-1:0]   sreg_q;
  logic [IDX_W-1:0]    idx_q;
  logic [CNT_W-1:0]    cnt_q;

  logic [DATA_W-1:0]   sreg_shifted;
  logic [SYM_W-1:0]    cur_sym;
  logic                acc;
  logic                xfer;
  logic                lastx;
  logic                pend_wr;
  logic                pend_take;
  logic                pend_full;
  logic [DATA_W-1:0]   pend_data;

  // Symbol selection and the shift direction both follow MSB_FIRST so the
  // emitted symbol is always at the same end of the shift register.
  always_comb begin
    cur_sym      = '0;
    sreg_shifted = '0;
    if (MSB_FIRST != 0) begin
      cur_sym      = sreg_q[DATA_W-1 -: SYM_W];
      sreg_shifted = sreg_q << SYM_W;
    end else begin
      cur_sym      = sreg_q[SYM_W-1:0];
      sreg_shifted = sreg_q >> SYM_W;
    end
  end

  assign num_valid = (state_q == ST_SHIFT);
  assign num       = num_valid ? cur_sym : SYM_W'(SYM_IDLE);
  assign num_last  = num_valid && (idx_q == IDX_LAST);

  // in_ready depends only on registered state and reset, never on in_valid.
  assign in_ready  = !reset && !pend_full;

  assign acc   = in_valid && in_ready;
  assign xfer  = num_valid && num_ready;
  assign lastx = xfer && num_last;

  // A word arriving while another shifts goes to the pending buffer, unless
  // the current word finishes this very cycle (then it loads straight in).
  assign pend_wr   = acc && (state_q == ST_SHIFT) && !lastx;
  assign pend_take = lastx && pend_full;

  assign busy      = num_valid || pend_full;
  assign sym_count = cnt_q;

  word_pend_buf #(
    .W (DATA_W)
  ) u_pend_buf (
    .clk       (clk),
    .reset     (reset),
    .wr_i      (pend_wr),
    .wr_data_i (in_data),
    .take_i    (pend_take),
    .full_o    (pend_full),
    .data_o    (pend_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      sreg_q  <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      if (xfer && (cnt_q != CNT_MAX)) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end

      case (state_q)
        ST_IDLE: begin
          if (acc) begin
            sreg_q  <= in_data;
            idx_q   <= '0;
            state_q <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (xfer) begin
            if (!num_last) begin
              sreg_q <= sreg_shifted;
              idx_q  <= idx_q + IDX_W'(1);
            end else if (pend_full) begin
              sreg_q <= pend_data;
              idx_q  <= '0;
            end else if (acc) begin
              sreg_q <= in_data;
              idx_q  <= '0;
            end else begin
              sreg_q  <= '0;
              idx_q   <= '0;
              state_q <= ST_IDLE;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_symbol_serializer.sv
// tb/tb_symbol_serializer.sv - scoreboard bench for symbol_serializer
module tb_symbol_serializer;

  typedef struct packed {
    logic [1:0] sym;
    logic       last;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       num_ready = 1'b0;

  logic        m_rdy, m_valid, m_last, m_busy;
  logic [1:0]  m_num;
  logic [15:0] m_cnt;
  logic        l_rdy, l_valid, l_last, l_busy;
  logic [1:0]  l_num;
  logic [15:0] l_cnt;
  logic        s_rdy, s_valid, s_last, s_busy;
  logic [1:0]  s_num;
  logic [3:0]  s_cnt;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t q_m[$];
  exp_t q_l[$];
  exp_t q_s[$];
  int   exp_m = 0;
  int   exp_l = 0;
  int   exp_s = 0;

  always #5 clk = ~clk;

  symbol_serializer #(.DATA_W(8), .SYM_W(2), .MSB_FIRST(1), .CNT_W(16)) dut_m (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(m_rdy),
    .num(m_num), .num_valid(m_valid), .num_ready(num_ready), .num_last(m_last),
    .busy(m_busy), .sym_count(m_cnt));

  symbol_serializer #(.DATA_W(8), .SYM_W(2), .MSB_FIRST(0), .CNT_W(16)) dut_l (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(l_rdy),
    .num(l_num), .num_valid(l_valid), .num_ready(num_ready), .num_last(l_last),
    .busy(l_busy), .sym_count(l_cnt));

  symbol_serializer #(.DATA_W(8), .SYM_W(2), .MSB_FIRST(1), .CNT_W(4)) dut_s (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(s_rdy),
    .num(s_num), .num_valid(s_valid), .num_ready(num_ready), .num_last(s_last),
    .busy(s_busy), .sym_count(s_cnt));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic extra_sym(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: symbol transferred with empty scoreboard at %0t", name, $time);
  endtask

  task automatic push_exp(input logic [7:0] w);
    for (int k = 0; k < 4; k++) begin
      q_m.push_back('{sym: w[7-2*k -: 2], last: (k == 3)});
      q_s.push_back('{sym: w[7-2*k -: 2], last: (k == 3)});
      q_l.push_back('{sym: w[2*k +: 2],   last: (k == 3)});
    end
  endtask

  task automatic send(input logic [7:0] w);
    logic ok;
    int   n;
    in_data  = w;
    in_valid = 1'b1;
    ok = 1'b0;
    n  = 0;
    while (!ok && n < 50) begin
      @(negedge clk);
      ok = m_rdy;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: word %0h never accepted", w);
    end else begin
      push_exp(w);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((m_busy || l_busy || s_busy) && n < 100);
    chk("drain_done", 32'(n < 100), 32'(1));
    chk("drain_m_valid", 32'(m_valid), 32'(0));
    chk("drain_qm_empty", 32'(q_m.size()), 32'(0));
    chk("drain_ql_empty", 32'(q_l.size()), 32'(0));
    chk("drain_qs_empty", 32'(q_s.size()), 32'(0));
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    num_ready = 1'b0;
    in_valid  = 1'b0;
    q_m.delete();
    q_l.delete();
    q_s.delete();
    @(posedge clk);
    #1;
    reset     = 1'b0;
    num_ready = 1'b1;
  endtask

  // Monitors: pop expected symbol on every transfer, track counters.
  always @(negedge clk) begin
    exp_t e;
    if (!m_valid) chk("m_idle_num", 32'(m_num), 32'(0));
    if (m_valid && num_ready && !reset) begin
      if (q_m.size() == 0) extra_sym("m_extra");
      else begin
        e = q_m.pop_front();
        chk("m_sym", 32'(m_num), 32'(e.sym));
        chk("m_last", 32'(m_last), 32'(e.last));
      end
    end
    chk("m_cnt", 32'(m_cnt), 32'(exp_m));
    if (reset) exp_m = 0;
    else if (m_valid && num_ready) exp_m++;
  end

  always @(negedge clk) begin
    exp_t e;
    if (!l_valid) chk("l_idle_num", 32'(l_num), 32'(0));
    if (l_valid && num_ready && !reset) begin
      if (q_l.size() == 0) extra_sym("l_extra");
      else begin
        e = q_l.pop_front();
        chk("l_sym", 32'(l_num), 32'(e.sym));
        chk("l_last", 32'(l_last), 32'(e.last));
      end
    end
    chk("l_cnt", 32'(l_cnt), 32'(exp_l));
    if (reset) exp_l = 0;
    else if (l_valid && num_ready) exp_l++;
  end

  always @(negedge clk) begin
    exp_t e;
    if (!s_valid) chk("s_idle_num", 32'(s_num), 32'(0));
    if (s_valid && num_ready && !reset) begin
      if (q_s.size() == 0) extra_sym("s_extra");
      else begin
        e = q_s.pop_front();
        chk("s_sym", 32'(s_num), 32'(e.sym));
        chk("s_last", 32'(s_last), 32'(e.last));
      end
    end
    chk("s_cnt", 32'(s_cnt), 32'(exp_s));
    if (reset) exp_s = 0;
    else if (s_valid && num_ready && exp_s < 15) exp_s++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(m_rdy), 32'(0));
    chk("rst_valid", 32'(m_valid), 32'(0));
    chk("rst_busy", 32'(m_busy), 32'(0));
    chk("rst_cnt", 32'(m_cnt), 32'(0));
    @(posedge clk);
    #1;
    reset     = 1'b0;
    num_ready = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(m_rdy), 32'(1));
    chk("post_rst_l_in_ready", 32'(l_rdy), 32'(1));
    chk("post_rst_s_in_ready", 32'(s_rdy), 32'(1));
    @(posedge clk);
    #1;

    // Single word: 01,10,11,00 (lsb: 00,11,10,01), one-cycle latency
    send(8'b01101100);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("t1_valid", 32'(m_valid), 32'(1));
      chk("t1_last", 32'(m_last), 32'(c == 3));
    end
    @(negedge clk);
    chk("t1_valid_end", 32'(m_valid), 32'(0));
    chk("t1_busy_end", 32'(m_busy), 32'(0));
    chk("t1_cnt", 32'(m_cnt), 32'(4));

    // Back-to-back: E4 then 1B, no gap between words
    do_reset();
    send(8'hE4);
    send(8'h1B);
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      chk("t2_valid", 32'(m_valid), 32'(1));
      chk("t2_in_ready", 32'(m_rdy), 32'(c >= 3));
      chk("t2_busy", 32'(m_busy), 32'(1));
    end
    @(negedge clk);
    chk("t2_valid_end", 32'(m_valid), 32'(0));
    chk("t2_busy_end", 32'(m_busy), 32'(0));
    chk("t2_cnt", 32'(m_cnt), 32'(8));

    // Backpressure at idx=1 of D2 (11,01,00,10); word 39 accepted during stall
    do_reset();
    send(8'hD2);
    @(posedge clk);
    #1;
    num_ready = 1'b0;
    in_data   = 8'h39;
    in_valid  = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("t3_num", 32'(m_num), 32'(2'b01));
      chk("t3_last", 32'(m_last), 32'(0));
      chk("t3_valid", 32'(m_valid), 32'(1));
      chk("t3_cnt", 32'(m_cnt), 32'(1));
      chk("t3_in_ready", 32'(m_rdy), 32'(c == 0));
      chk("t3_busy", 32'(m_busy), 32'(1));
      @(posedge clk);
      #1;
      if (c == 0) begin
        in_valid = 1'b0;
        push_exp(8'h39);
      end
    end
    num_ready = 1'b1;
    drain();
    chk("t3_cnt_end", 32'(m_cnt), 32'(8));

    // Reset at idx=2 with a pending word
    do_reset();
    send(8'hA5);
    send(8'h3C);
    @(posedge clk);
    #1;
    reset     = 1'b1;
    num_ready = 1'b0;
    q_m.delete();
    q_l.delete();
    q_s.delete();
    @(negedge clk);
    chk("t4_in_ready_rst", 32'(m_rdy), 32'(0));
    @(posedge clk);
    #1;
    reset     = 1'b0;
    num_ready = 1'b1;
    @(negedge clk);
    chk("t4_valid", 32'(m_valid), 32'(0));
    chk("t4_busy", 32'(m_busy), 32'(0));
    chk("t4_cnt", 32'(m_cnt), 32'(0));
    chk("t4_in_ready", 32'(m_rdy), 32'(1));
    @(posedge clk);
    #1;
    send(8'h6C);
    drain();
    chk("t4_cnt_end", 32'(m_cnt), 32'(4));

    // Saturation: 5 words = 20 symbols; CNT_W=4 instance holds at 15
    do_reset();
    send(8'h6C);
    send(8'hE4);
    send(8'h1B);
    send(8'hD2);
    send(8'hA5);
    drain();
    chk("t5_sat_cnt", 32'(s_cnt), 32'(15));
    chk("t5_m_cnt", 32'(m_cnt), 32'(20));
    chk("t5_l_cnt", 32'(l_cnt), 32'(20));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
